// File: rtl/uart_tx_fifo.sv
// UART transmitter with a push FIFO, runtime baud divisor and 1/2 stop bits.
// Define UART_TX_PARITY_EN to add the ParityEn/ParityOdd ports and a parity bit state.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic [DIV_W-1:0]              Divisor,
    input  logic                          StopTwo,
`ifdef UART_TX_PARITY_EN
    input  logic                          ParityEn,
    input  logic                          ParityOdd,
`endif
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_BITS-1:0]          in_data,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          busy,
    output logic                          finish,
    output logic                          TX
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int BIT_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0]   mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [DIV_W-1:0]       cnt_q, cnt_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic                   stop_two_q, stop_two_d;
    logic                   stop_rem_q, stop_rem_d;
    logic                   tx_q, tx_d;
    logic                   finish_q, finish_d;
    logic                   busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic                   par_en_q, par_en_d;
    logic                   par_q, par_d;
`endif
    logic                   push;
    logic                   pop;
    logic                   tick;
    logic [DATA_BITS-1:0]   head;

    assign in_ready = (level_q != LVL_W'(FIFO_DEPTH));
    assign level    = level_q;
    assign busy     = busy_q;
    assign finish   = finish_q;
    assign TX       = tx_q;

    always_comb begin
        push       = in_valid && in_ready;
        pop        = 1'b0;
        tick       = (cnt_q == '0);
        head       = mem_q[rd_ptr_q];
        state_d    = state_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        shift_d    = shift_q;
        div_d      = div_q;
        cnt_d      = tick ? div_q : cnt_q - DIV_W'(1);
        bit_d      = bit_q;
        stop_two_d = stop_two_q;
        stop_rem_d = stop_rem_q;
        tx_d       = tx_q;
        finish_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_en_d   = par_en_q;
        par_d      = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = cnt_q;
                pop   = (level_q != '0);
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d   = BIT_W'(DATA_BITS - 1);
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_q != '0) begin
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q - BIT_W'(1);
                    end else begin
                        state_d    = S_STOP;
                        tx_d       = 1'b1;
                        stop_rem_d = stop_two_q;
`ifdef UART_TX_PARITY_EN
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    state_d    = S_STOP;
                    tx_d       = 1'b1;
                    stop_rem_d = stop_two_q;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (stop_rem_q) begin
                        stop_rem_d = 1'b0;
                    end else begin
                        finish_d = 1'b1;
                        state_d  = S_IDLE;
                        pop      = (level_q != '0);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A pop always starts a new frame: frame config is captured only here.
        if (pop) begin
            state_d    = S_START;
            tx_d       = 1'b0;
            shift_d    = head;
            div_d      = Divisor;
            cnt_d      = Divisor;
            stop_two_d = StopTwo;
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
`ifdef UART_TX_PARITY_EN
            par_en_d   = ParityEn;
            par_d      = (^head) ^ ParityOdd;
`endif
        end
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (push && !pop) level_d = level_q + LVL_W'(1);
        else if (pop && !push) level_d = level_q - LVL_W'(1);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge Clock) begin
        mem_q <= mem_d;
        if (Reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            shift_q    <= '0;
            div_q      <= '0;
            cnt_q      <= '0;
            bit_q      <= '0;
            stop_two_q <= 1'b0;
            stop_rem_q <= 1'b0;
            tx_q       <= 1'b1;
            finish_q   <= 1'b0;
            busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= 1'b0;
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            shift_q    <= shift_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            stop_two_q <= stop_two_d;
            stop_rem_q <= stop_rem_d;
            tx_q       <= tx_d;
            finish_q   <= finish_d;
            busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= par_en_d;
            par_q      <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: frame waveforms, FIFO handshake, back-to-back and reset.
module tb_uart_tx_fifo;
    logic        clk;
    logic        rst;
    logic [15:0] divisor;
    logic        stop_two;
`ifdef UART_TX_PARITY_EN
    logic        parity_en;
    logic        parity_odd;
`endif
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [2:0]  level;
    logic        busy;
    logic        finish;
    logic        TX;

    int checks;
    int errors;
    int cyc = 0;

    uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4), .DIV_W(16)) dut (
        .Clock    (clk),
        .Reset    (rst),
        .Divisor  (divisor),
        .StopTwo  (stop_two),
`ifdef UART_TX_PARITY_EN
        .ParityEn (parity_en),
        .ParityOdd(parity_odd),
`endif
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .level    (level),
        .busy     (busy),
        .finish   (finish),
        .TX       (TX)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog");
    end

    task automatic push_word(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Checks one frame clock by clock; skip = frame clocks already elapsed on entry.
    task automatic expect_frame(input logic [7:0] data, input int div, input int stops,
                                input bit par_on, input bit par_odd, input int skip,
                                output int t_fall);
        logic pat [16];
        int   nbits;
        int   per;
        int   n;
        int   prints;
        per    = div + 1;
        nbits  = 0;
        prints = 0;
        t_fall = -1;
        for (int b = 0; b < 16; b++) pat[b] = 1'b1;
        pat[0] = 1'b0;
        nbits  = 1;
        for (int b = 0; b < 8; b++) begin
            pat[nbits] = data[b];
            nbits++;
        end
        if (par_on) begin
            pat[nbits] = (^data) ^ par_odd;
            nbits++;
        end
        nbits = nbits + stops;
        n = 0;
        while (TX !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (TX !== 1'b0) begin
            errors++;
            $display("FAIL frame_start data=%h: TX=%b, expected 0 within 5000 clk", data, TX);
            return;
        end
        t_fall = cyc - skip;
        for (int i = skip; i < nbits * per; i++) begin
            if (i != skip) @(negedge clk);
            checks++;
            if (TX !== pat[i / per]) begin
                errors++;
                if (prints < 8) $display("FAIL frame_bit data=%h bit %0d clk %0d: TX=%b, expected %b",
                                         data, i / per, i, TX, pat[i / per]);
                prints++;
            end
            if (i > 0) begin
                checks++;
                if (finish !== 1'b0) begin
                    errors++;
                    if (prints < 8) $display("FAIL frame_finish_early data=%h clk %0d: finish=%b, expected 0",
                                             data, i, finish);
                    prints++;
                end
            end
        end
        @(negedge clk);
        checks++;
        if (finish !== 1'b1) begin
            errors++;
            $display("FAIL frame_finish data=%h: finish=%b, expected 1", data, finish);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (TX !== 1'b1 || level !== 3'd0 || in_ready !== 1'b1 || busy !== 1'b0 || finish !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: TX=%b level=%0d in_ready=%b busy=%b finish=%b, expected 1 0 1 0 0",
                     TX, level, in_ready, busy, finish);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single;
        int tf;
        divisor  = 16'd3;
        stop_two = 1'b0;
        push_word(8'hA5);
        checks++;
        if (TX !== 1'b1 || level !== 3'd1) begin
            errors++;
            $display("FAIL single_accept: TX=%b level=%0d, expected 1 1", TX, level);
        end
        @(negedge clk);
        checks++;
        if (TX !== 1'b0 || busy !== 1'b1 || level !== 3'd0) begin
            errors++;
            $display("FAIL single_latency: TX=%b busy=%b level=%0d, expected 0 1 0", TX, busy, level);
        end
        expect_frame(8'hA5, 3, 1, 1'b0, 1'b0, 0, tf);
        checks++;
        if (TX !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: TX=%b busy=%b, expected 1 0", TX, busy);
        end
    endtask

    task automatic test_two_stop;
        int tf;
        divisor  = 16'd3;
        stop_two = 1'b1;
        push_word(8'h00);
        @(negedge clk);
        divisor  = 16'd0;
        stop_two = 1'b0;
        expect_frame(8'h00, 3, 2, 1'b0, 1'b0, 0, tf);
        checks++;
        if (TX !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL two_stop_idle: TX=%b busy=%b, expected 1 0", TX, busy);
        end
    endtask

    task automatic test_fifo_full;
        int acc;
        int tf [5];
        divisor = 16'd99;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h11 * (i + 1));
            if (in_ready === 1'b1) acc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (acc !== 5 || level !== 3'd4 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fifo_full: accepted=%0d level=%0d in_ready=%b, expected 5 4 0", acc, level, in_ready);
        end
        for (int j = 0; j < 5; j++) begin
            expect_frame(8'(8'h11 * (j + 1)), 99, 1, 1'b0, 1'b0, (j == 0) ? 4 : 0, tf[j]);
            if (j > 0) begin
                checks++;
                if (tf[j] - tf[j-1] !== 1000) begin
                    errors++;
                    $display("FAIL fifo_gap frame %0d: spacing=%0d clk, expected 1000", j, tf[j] - tf[j-1]);
                end
            end
        end
        checks++;
        if (TX !== 1'b1 || busy !== 1'b0 || level !== 3'd0) begin
            errors++;
            $display("FAIL fifo_drained: TX=%b busy=%b level=%0d, expected 1 0 0", TX, busy, level);
        end
    endtask

    task automatic test_back_to_back;
        int tf0;
        int tf1;
        divisor  = 16'd0;
        in_valid = 1'b1;
        in_data  = 8'h3C;
        @(negedge clk);
        in_data  = 8'hC3;
        @(negedge clk);
        in_valid = 1'b0;
        expect_frame(8'h3C, 0, 1, 1'b0, 1'b0, 0, tf0);
        expect_frame(8'hC3, 0, 1, 1'b0, 1'b0, 0, tf1);
        checks++;
        if (tf1 - tf0 !== 10) begin
            errors++;
            $display("FAIL b2b_gap: spacing=%0d clk, expected 10", tf1 - tf0);
        end
        checks++;
        if (TX !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: TX=%b busy=%b, expected 1 0", TX, busy);
        end
    endtask

    task automatic test_reset_mid_frame;
        int tf;
        int bad;
        divisor  = 16'd3;
        in_valid = 1'b1;
        in_data  = 8'h55;
        @(negedge clk);
        in_data  = 8'h12;
        @(negedge clk);
        in_data  = 8'h34;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (16) @(negedge clk);
        checks++;
        if (TX !== 1'b0 || busy !== 1'b1 || level !== 3'd2) begin
            errors++;
            $display("FAIL mid_frame_pre: TX=%b busy=%b level=%0d, expected 0 1 2", TX, busy, level);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (TX !== 1'b1 || level !== 3'd0 || busy !== 1'b0 || finish !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_frame_reset: TX=%b level=%0d busy=%b finish=%b in_ready=%b, expected 1 0 0 0 1",
                     TX, level, busy, finish, in_ready);
        end
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (TX !== 1'b1 || finish !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL post_reset_quiet: %0d active clk, expected 0", bad);
        end
        push_word(8'h96);
        expect_frame(8'h96, 3, 1, 1'b0, 1'b0, 0, tf);
        checks++;
        if (TX !== 1'b1 || busy !== 1'b0 || level !== 3'd0) begin
            errors++;
            $display("FAIL post_reset_idle: TX=%b busy=%b level=%0d, expected 1 0 0", TX, busy, level);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        int tf;
        divisor    = 16'd1;
        parity_en  = 1'b1;
        parity_odd = 1'b0;
        push_word(8'h07);
        expect_frame(8'h07, 1, 1, 1'b1, 1'b0, 0, tf);
        parity_odd = 1'b1;
        push_word(8'h07);
        expect_frame(8'h07, 1, 1, 1'b1, 1'b1, 0, tf);
        parity_en  = 1'b0;
        parity_odd = 1'b0;
    endtask
`endif

    initial begin
        clk      = 1'b0;
        rst      = 1'b1;
        divisor  = 16'd3;
        stop_two = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
`ifdef UART_TX_PARITY_EN
        parity_en  = 1'b0;
        parity_odd = 1'b0;
`endif
        checks = 0;
        errors = 0;
        test_reset;
        test_single;
        test_two_stop;
        test_fifo_full;
        test_back_to_back;
        test_reset_mid_frame;
`ifdef UART_TX_PARITY_EN
        test_parity;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
